// File: rtl/mem_responder_pkg.sv
// Shared CPU package: memory responder FSM encoding, default memory geometry
// and the datapath constants used around MAR/MDR.
package mem_responder_pkg;

  // Default memory geometry and timing.
  localparam int MR_ADDR_W      = 9;
  localparam int MR_DATA_W      = 32;
  localparam int MR_WAIT_CYCLES = 2;

  // Wait counter width. It holds WAIT_CYCLES, which is at most 15.
  localparam int MR_CNT_W       = 4;

  // Datapath constants: the memory is word addressed.
  localparam int MAR_W          = MR_ADDR_W;
  localparam int MDR_W          = MR_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mr_state_e;

  // A command is accepted only when exactly one strobe is high.
  function automatic logic is_accept(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/mem_responder_ram_array.sv
// Word-wide single-port storage with a synchronous write and a
// combinational read.
// The read is combinational so that the responder can register the word into
// mem_rdata on the same edge that enters DONE.
module ram_array #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Synchronous write. Contents are deliberately not cleared by any reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder. It accepts read and write commands from the control unit
// and completes each command after WAIT_CYCLES wait states. The three-state
// FSM is IDLE -> (WAIT) -> DONE -> IDLE. The current state is exported on
// dbg_state.
//
// Handshake: mem_ready is high only in IDLE. A command is accepted on an edge
// in IDLE where exactly one of read and ram_write is high. mem_done pulses for
// one cycle, WAIT_CYCLES+1 cycles after the accept edge. If both strobes are
// high in IDLE, the command is rejected and cmd_err pulses in the next cycle.
// Strobes seen outside IDLE are ignored.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = MR_ADDR_W,
  parameter int DATA_W      = MR_DATA_W,
  parameter int WAIT_CYCLES = MR_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              ram_write,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mdr_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_done,
  output logic              cmd_err,
  output logic [1:0]        dbg_state
);

  localparam logic [MR_CNT_W-1:0] WAIT_LD = MR_CNT_W'(WAIT_CYCLES);

  mr_state_e           state_q, state_d;
  logic [MR_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_wr_q, op_wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                enter_done;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_rdata;

  // Next-state, wait-counter and command-capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_accept(read, ram_write)) begin
          addr_d  = mar_addr;
          wdata_d = mdr_wdata;
          op_wr_d = ram_write;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
        end else if (read && ram_write) begin
          err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - MR_CNT_W'(1);
        if (cnt_q == MR_CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The access happens on the edge that enters DONE. A reset on that edge
  // aborts the access.
  always_comb begin
    enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    ram_we     = enter_done && op_wr_d && !clr;
    rdata_d    = rdata_q;
    if (enter_done && !op_wr_d) rdata_d = ram_rdata;
  end

  // Control state with synchronous reset. Reset takes priority over commands.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Captured command fields. They are only used while a command is in flight.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    op_wr_q <= op_wr_d;
  end

  ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .addr (addr_d),
    .wdata(wdata_d),
    .we   (ram_we),
    .rdata(ram_rdata)
  );

  assign mem_rdata = rdata_q;
  assign mem_ready = (state_q == ST_IDLE);
  assign mem_done  = (state_q == ST_DONE);
  assign cmd_err   = err_q;
  assign dbg_state = state_q;

endmodule
